// File: rtl/unidade_busca_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : unidade_busca_pkg
//  Purpose : Shared constants, the {pc, instr} entry layout and the fetch
//            address legality check used by the fetch unit.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package unidade_busca_pkg;

  localparam int          LARGURA_PALAVRA = 32;
  localparam int          BYTES_INSTR     = 4;
  localparam logic [31:0] PC_RESET_PADRAO = 32'h0000_0000;
  localparam int          LARGURA_ENTRADA = 2 * LARGURA_PALAVRA;  // {pc, instr}

  typedef struct packed {
    logic [LARGURA_PALAVRA-1:0] pc;
    logic [LARGURA_PALAVRA-1:0] instr;
  } entrada_t;

  // Misaligned or past the last ROM word; limite_bytes is 4*ROM words.
  function automatic logic endereco_ilegal(
    input logic [LARGURA_PALAVRA-1:0] endereco,
    input logic [LARGURA_PALAVRA-1:0] limite_bytes
  );
    return (endereco[1:0] != 2'b00) || (endereco >= limite_bytes);
  endfunction

endpackage : unidade_busca_pkg
`default_nettype wire

// File: rtl/unidade_busca_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : fifo_busca
//  Purpose : Synchronous prefetch FIFO with flush. The head entry is read
//            straight from the storage flops, so it is visible the cycle
//            after a push into an empty FIFO and stays stable until popped.
//  Ports   : clock, reset   - clock and synchronous active-high reset
//            push_i, pop_i  - write / remove head (ignored when not possible)
//            flush_i        - discard all entries (overrides push/pop)
//            dado_i         - entry to push
//            dado_o         - head entry
//            cheio_o        - FIFO holds DEPTH entries
//            vazio_o        - FIFO holds no entries
//  Rev     : 1.0  initial release
// ============================================================================
module fifo_busca #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] dado_i,
  output logic [WIDTH-1:0] dado_o,
  output logic             cheio_o,
  output logic             vazio_o
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CONT_W = $clog2(DEPTH) + 1;
  localparam logic [CONT_W-1:0] CONT_CHEIO = CONT_W'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CONT_W-1:0] cont_q,   cont_d;
  logic              pop_ok, push_ok;

  assign cheio_o = (cont_q == CONT_CHEIO);
  assign vazio_o = (cont_q == '0);
  assign dado_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only possible when the head leaves that cycle.
  assign pop_ok  = pop_i & ~vazio_o;
  assign push_ok = push_i & (~cheio_o | pop_ok);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cont_d   = cont_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cont_d   = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cont_d = cont_q + CONT_W'(1);
        2'b01:   cont_d = cont_q - CONT_W'(1);
        default: cont_d = cont_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cont_q   <= '0;
    end else begin
      if (!flush_i && push_ok) mem_q[wr_ptr_q] <= dado_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cont_q   <= cont_d;
    end
  end

endmodule : fifo_busca
`default_nettype wire

// File: rtl/unidade_busca.sv
`default_nettype none
// ============================================================================
//  Module  : unidade_busca
//  Purpose : Fetch controller. Owns the fetch PC, addresses the instruction
//            ROM, buffers {pc, instr} in a prefetch FIFO and presents the
//            head to decode over valid/ready. Redirects flush and refetch;
//            illegal fetch addresses raise a sticky error.
//  Ports   : clock, reset          - clock, synchronous active-high reset
//            endereco_PC    (out)  - byte address to the ROM (= fetch PC)
//            instrucao_in   (in)   - ROM word for endereco_PC, same cycle
//            desvio_valido  (in)   - redirect request
//            desvio_alvo    (in)   - redirect target byte address
//            instrucao_out  (out)  - instruction at FIFO head
//            pc_out         (out)  - byte address of instrucao_out
//            valido_out     (out)  - head valid
//            pronto_in      (in)   - decode accepts head
//            erro_endereco  (out)  - sticky illegal-address flag
//  Rev     : 1.0  initial release
// ============================================================================
module unidade_busca
  import unidade_busca_pkg::*;
#(
  parameter logic [31:0] PC_RESET        = PC_RESET_PADRAO,
  parameter int          FIFO_PROF       = 2,
  parameter int          MEMORIA_TAMANHO = 64
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] endereco_PC,
  input  logic [31:0] instrucao_in,
  input  logic        desvio_valido,
  input  logic [31:0] desvio_alvo,
  output logic [31:0] instrucao_out,
  output logic [31:0] pc_out,
  output logic        valido_out,
  input  logic        pronto_in,
  output logic        erro_endereco
);

  localparam logic [31:0] LIMITE_BYTES = 32'(BYTES_INSTR * MEMORIA_TAMANHO);

  logic [31:0] pc_busca_q, pc_busca_d;
  logic        erro_q,     erro_d;
  logic        pc_ilegal;
  logic        cheio, vazio;
  logic        pop, push, flush;
  entrada_t    entrada_in, entrada_head;

  assign endereco_PC   = pc_busca_q;
  assign erro_endereco = erro_q;
  assign pc_ilegal     = endereco_ilegal(pc_busca_q, LIMITE_BYTES);

  assign valido_out    = ~vazio;
  assign pop           = valido_out & pronto_in;
  assign push          = ~desvio_valido & ~erro_q & ~pc_ilegal & (~cheio | pop);
  // Once in error the unit is frozen; a redirect would otherwise also drop
  // entries that are still allowed to drain.
  assign flush         = desvio_valido & ~erro_q;

  assign entrada_in.pc    = pc_busca_q;
  assign entrada_in.instr = instrucao_in;
  assign pc_out           = entrada_head.pc;
  assign instrucao_out    = entrada_head.instr;

  always_comb begin
    pc_busca_d = pc_busca_q;
    erro_d     = erro_q;
    if (flush) begin
      pc_busca_d = desvio_alvo;
    end else if (push) begin
      pc_busca_d = pc_busca_q + 32'(BYTES_INSTR);
    end
    // The check looks at the current PC, so an illegal redirect target
    // raises the flag one cycle after the redirect.
    if (!desvio_valido && pc_ilegal) erro_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_busca_q <= PC_RESET;
      erro_q     <= 1'b0;
    end else begin
      pc_busca_q <= pc_busca_d;
      erro_q     <= erro_d;
    end
  end

  fifo_busca #(
    .WIDTH (LARGURA_ENTRADA),
    .DEPTH (FIFO_PROF)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .dado_i  (entrada_in),
    .dado_o  (entrada_head),
    .cheio_o (cheio),
    .vazio_o (vazio)
  );

endmodule : unidade_busca
`default_nettype wire

// File: tb/tb_unidade_busca.sv
`default_nettype none
// ============================================================================
//  Module  : tb_unidade_busca
//  Purpose : Directed self-checking bench for the fetch unit with a ROM
//            model whose word k holds 32'hA000_0000 + k.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_unidade_busca;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] endereco_PC;
  logic [31:0] instrucao_in;
  logic        desvio_valido;
  logic [31:0] desvio_alvo;
  logic [31:0] instrucao_out;
  logic [31:0] pc_out;
  logic        valido_out;
  logic        pronto_in;
  logic        erro_endereco;

  int n_assert = 0;
  int n_falha  = 0;

  always #5 clock = ~clock;

  // ROM model: word index = byte address / 4
  assign instrucao_in = 32'hA000_0000 + {2'b00, endereco_PC[31:2]};

  unidade_busca #(
    .PC_RESET        (32'h0000_0000),
    .FIFO_PROF       (2),
    .MEMORIA_TAMANHO (64)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .endereco_PC   (endereco_PC),
    .instrucao_in  (instrucao_in),
    .desvio_valido (desvio_valido),
    .desvio_alvo   (desvio_alvo),
    .instrucao_out (instrucao_out),
    .pc_out        (pc_out),
    .valido_out    (valido_out),
    .pronto_in     (pronto_in),
    .erro_endereco (erro_endereco)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_falha++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    pronto_in     = 1'b0;
    desvio_valido = 1'b0;
    desvio_alvo   = 32'h0;
    tick();
    tick();

    // Reset state
    chk("rst_valido", {31'b0, valido_out}, 32'd0);
    chk("rst_instr",  instrucao_out, 32'h0);
    chk("rst_pc",     pc_out, 32'h0);
    chk("rst_erro",   {31'b0, erro_endereco}, 32'd0);
    chk("rst_end",    endereco_PC, 32'h0);

    // 1: streaming from reset
    reset     = 1'b0;
    pronto_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_valido", {31'b0, valido_out}, 32'd1);
      chk("t1_pc",     pc_out, 32'(4 * k));
      chk("t1_instr",  instrucao_out, 32'hA000_0000 + 32'(k));
    end

    // 2: back-pressure fills the FIFO
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    pronto_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_hold_pc", pc_out, 32'h0);
      chk("t2_hold_vl", {31'b0, valido_out}, 32'd1);
    end
    chk("t2_end",   endereco_PC, 32'h8);
    chk("t2_instr", instrucao_out, 32'hA000_0000);
    pronto_in = 1'b1;
    tick();
    chk("t2_pc4", pc_out, 32'h4);
    chk("t2_vl4", {31'b0, valido_out}, 32'd1);
    tick();
    chk("t2_pc8", pc_out, 32'h8);
    chk("t2_in8", instrucao_out, 32'hA000_0002);

    // 3: redirect to 0x40 while head = pc 8 is accepted
    desvio_valido = 1'b1;
    desvio_alvo   = 32'h40;
    tick();
    desvio_valido = 1'b0;
    chk("t3_vl_gap", {31'b0, valido_out}, 32'd0);
    chk("t3_end",    endereco_PC, 32'h40);
    tick();
    chk("t3_vl",   {31'b0, valido_out}, 32'd1);
    chk("t3_pc40", pc_out, 32'h40);
    chk("t3_in40", instrucao_out, 32'hA000_0010);
    tick();
    chk("t3_pc44", pc_out, 32'h44);
    chk("t3_in44", instrucao_out, 32'hA000_0011);

    // 4: redirect to a misaligned target
    desvio_valido = 1'b1;
    desvio_alvo   = 32'h42;
    tick();
    desvio_valido = 1'b0;
    chk("t4_erro0", {31'b0, erro_endereco}, 32'd0);
    chk("t4_vl0",   {31'b0, valido_out}, 32'd0);
    tick();
    chk("t4_erro1", {31'b0, erro_endereco}, 32'd1);
    chk("t4_vl1",   {31'b0, valido_out}, 32'd0);
    chk("t4_end1",  endereco_PC, 32'h42);
    desvio_valido = 1'b1;  // ignored while in error
    desvio_alvo   = 32'h10;
    tick();
    desvio_valido = 1'b0;
    tick();
    chk("t4_frozen",  endereco_PC, 32'h42);
    chk("t4_vl2",     {31'b0, valido_out}, 32'd0);
    chk("t4_sticky",  {31'b0, erro_endereco}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_rst_erro", {31'b0, erro_endereco}, 32'd0);
    chk("t4_rst_end",  endereco_PC, 32'h0);
    chk("t4_rst_vl",   {31'b0, valido_out}, 32'd0);
    tick();
    chk("t4_re_vl", {31'b0, valido_out}, 32'd1);
    chk("t4_re_pc", pc_out, 32'h0);

    // 5: sequential run off the end of the ROM
    for (int k = 1; k < 64; k++) begin
      tick();
      chk("t5_pc", pc_out, 32'(4 * k));
    end
    chk("t5_in_fc",   instrucao_out, 32'hA000_003F);
    chk("t5_end_100", endereco_PC, 32'h100);
    chk("t5_erro0",   {31'b0, erro_endereco}, 32'd0);
    tick();
    chk("t5_erro1", {31'b0, erro_endereco}, 32'd1);
    chk("t5_vl0",   {31'b0, valido_out}, 32'd0);
    tick();
    chk("t5_vl1",  {31'b0, valido_out}, 32'd0);
    chk("t5_end",  endereco_PC, 32'h100);

    // 6: reset during a redirect with FIFO full
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    pronto_in = 1'b0;
    tick();
    tick();
    chk("t6_full_end", endereco_PC, 32'h8);
    chk("t6_full_vl",  {31'b0, valido_out}, 32'd1);
    reset         = 1'b1;
    desvio_valido = 1'b1;
    desvio_alvo   = 32'h80;
    tick();
    chk("t6_vl",    {31'b0, valido_out}, 32'd0);
    chk("t6_erro",  {31'b0, erro_endereco}, 32'd0);
    chk("t6_end",   endereco_PC, 32'h0);
    chk("t6_pc",    pc_out, 32'h0);
    chk("t6_instr", instrucao_out, 32'h0);
    reset         = 1'b0;
    desvio_valido = 1'b0;
    tick();
    chk("t6_re_vl", {31'b0, valido_out}, 32'd1);
    chk("t6_re_pc", pc_out, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_falha);
    $finish;
  end

endmodule : tb_unidade_busca
`default_nettype wire
